// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for load-use stall detection.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writebacks to the read ports.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     iss_we_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
   input  logic [NUM_RD-1:0]        rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   output logic                     stallreq_o,
   output logic [ADDR_W:0]          busy_cnt_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] ra;

   // Later ports overwrite earlier ones, so the highest port index wins on collision.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] != '0)) begin
            mem_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = wr_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // Ordering matters: flush, then writeback clears, then issue sets (issue wins).
   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         if (wr_en_i[k]) begin
            busy_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (iss_we_i && (iss_addr_i != '0)) begin
         busy_d[iss_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      ra        = '0;
      for (int unsigned j = 0; j < NUM_RD; j++) begin
         ra = rd_addr_i[j*ADDR_W +: ADDR_W];
         if (!rst && rd_en_i[j] && (ra != '0)) begin
            rd_data_o[j*DATA_W +: DATA_W] = mem_q[ra];
            rd_busy_o[j]                  = busy_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
            for (int unsigned k = 0; k < NUM_WR; k++) begin
               if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == ra)) begin
                  rd_data_o[j*DATA_W +: DATA_W] = wr_data_i[k*DATA_W +: DATA_W];
                  rd_busy_o[j]                  = 1'b0;
               end
            end
`endif
         end
      end
   end

   assign stallreq_o = |rd_busy_o;
   assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected read-port results, a negedge monitor checks them.
module tb_regfile_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            iss_we;
   logic [AW-1:0]   iss_addr;
   logic [NW-1:0]   wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR-1:0]   rd_en;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]   rd_busy;
   logic            stall;
   logic [AW:0]     busy_cnt;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .iss_we_i   (iss_we),
      .iss_addr_i (iss_addr),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_busy_o  (rd_busy),
      .stallreq_o (stall),
      .busy_cnt_o (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] data;
      logic        busy;
      logic        stl;
      logic [5:0]  cnt;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

`ifdef REGFILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] d;
         e = q.pop_front();
         d = rd_data[e.port*DW +: DW];
         total++;
         if (d !== e.data || rd_busy[e.port] !== e.busy || stall !== e.stl || busy_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s port%0d: got data=%h busy=%b stall=%b cnt=%0d, want data=%h busy=%b stall=%b cnt=%0d",
                     e.name, e.port, d, rd_busy[e.port], stall, busy_cnt, e.data, e.busy, e.stl, e.cnt);
         end
      end
   end

   task automatic clear_in();
      flush = 0; iss_we = 0; iss_addr = '0;
      wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_en = '0; rd_addr = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic rd(input int j, input int a);
      rd_en[j] = 1'b1;
      rd_addr[j*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int k, input int a, input logic [31:0] d);
      wr_en[k] = 1'b1;
      wr_addr[k*AW +: AW] = AW'(a);
      wr_data[k*DW +: DW] = d;
   endtask

   task automatic iss(input int a);
      iss_we = 1'b1;
      iss_addr = AW'(a);
   endtask

   task automatic expect_rd(input string n, input int p, input logic [31:0] d,
                            input logic b, input logic s, input int c);
      exp_t e;
      e.name = n; e.port = p; e.data = d; e.busy = b; e.stl = s; e.cnt = 6'(c);
      q.push_back(e);
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      rd(0, 5);
      #2;
      expect_rd("reset_state", 0, 32'h0, 0, 0, 0);
      cyc();
      rst = 1'b0;

      // write x5, then mid-cycle asynchronous reset
      cyc(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
      expect_rd("x5_write_cycle", 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
      cyc(); rd(0, 5); iss(6);
      expect_rd("x5_written", 0, 32'hDEADBEEF, 0, 0, 0);
      cyc(); rd(0, 5);
      #2 rst = 1'b1;
      expect_rd("async_reset_rd", 0, 32'h0, 0, 0, 0);
      cyc(); rst = 1'b0; rd(0, 5); rd(1, 6);
      expect_rd("after_reset_x5", 0, 32'h0, 0, 0, 0);
      expect_rd("after_reset_x6", 1, 32'h0, 0, 0, 0);

      // x0 handling
      cyc(); wr(0, 0, 32'h1234); iss(0); rd(0, 0);
      expect_rd("x0_same_cycle", 0, 32'h0, 0, 0, 0);
      cyc(); rd(0, 0); rd(1, 0);
      expect_rd("x0_p0", 0, 32'h0, 0, 0, 0);
      expect_rd("x0_p1", 1, 32'h0, 0, 0, 0);

      // load-use
      cyc(); iss(7); rd(1, 7);
      expect_rd("lu_issue", 1, 32'h0, 0, 0, 0);
      cyc(); rd(1, 7);
      expect_rd("lu_busy", 1, 32'h0, 1, 1, 1);
      cyc(); wr(1, 7, 32'hA5A5A5A5); rd(1, 7);
      expect_rd("lu_wb", 1, BYP ? 32'hA5A5A5A5 : 32'h0, !BYP, !BYP, 1);
      cyc(); rd(1, 7);
      expect_rd("lu_done", 1, 32'hA5A5A5A5, 0, 0, 0);

      // write collision
      cyc(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(0, 3);
      expect_rd("coll_same", 0, BYP ? 32'h22 : 32'h0, 0, 0, 0);
      cyc(); rd(0, 3); rd(1, 3);
      expect_rd("coll_p0", 0, 32'h22, 0, 0, 0);
      expect_rd("coll_p1", 1, 32'h22, 0, 0, 0);

      // issue vs writeback race
      cyc(); iss(9); wr(0, 9, 32'h99); rd(0, 9);
      expect_rd("race_same", 0, BYP ? 32'h99 : 32'h0, 0, 0, 0);
      cyc(); rd(0, 9);
      expect_rd("race_busy", 0, 32'h99, 1, 1, 1);
      cyc(); wr(0, 9, 32'h100); rd(0, 9);
      expect_rd("race_wb", 0, BYP ? 32'h100 : 32'h99, !BYP, !BYP, 1);
      cyc(); rd(0, 9);
      expect_rd("race_clear", 0, 32'h100, 0, 0, 0);

      // flush
      cyc(); iss(1);
      cyc(); iss(2);
      cyc(); iss(3);
      cyc(); flush = 1'b1; iss(4); rd(0, 1); rd(1, 3);
      expect_rd("fl_pre_x1", 0, 32'h0, 1, 1, 3);
      expect_rd("fl_pre_x3", 1, 32'h22, 1, 1, 3);
      cyc(); rd(0, 4); rd(1, 1);
      expect_rd("fl_x4", 0, 32'h0, 1, 1, 1);
      expect_rd("fl_x1", 1, 32'h0, 0, 1, 1);
      cyc(); rd_addr[0 +: AW] = AW'(4); rd(1, 2);
      expect_rd("fl_rden_off", 0, 32'h0, 0, 0, 1);
      expect_rd("fl_x2", 1, 32'h0, 0, 0, 1);

      cyc();
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
